// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Loads a program into a 64-word instruction store from a byte stream and
// serves the fetch stage's combinational read port. While a load is in
// progress the core is held and the read port returns a NOP.
//
// Bytes arrive over a valid/ready handshake and are packed little-endian:
// byte k of each word lands in bits [8k+7:8k].
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   load_start   in   one-cycle load request, sampled only in IDLE
//   load_len     in   [6:0] words to load, clamped to DEPTH
//   in_valid     in   byte source has a byte
//   in_byte      in   [7:0] stream byte
//   in_ready     out  loader accepts a byte this cycle (LOAD only)
//   load_done    out  one-cycle pulse when a load completes
//   cpu_hold     out  core must stay held (LOAD and DONE)
//   address      in   [ADDR_W-1:0] fetch word address
//   instruction  out  [31:0] fetch read data
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [6:0]        load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              load_done,
  output logic              cpu_hold,
  input  logic [ADDR_W-1:0] address,
  output logic [31:0]       instruction
);

  // The word pointer is one bit wider than the address so that a full
  // 64-word load can reach its terminal count without wrapping.
  localparam int          PTR_W     = ADDR_W + 1;
  localparam logic [6:0]  DEPTH_LEN = 7'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [1:0]       byte_cnt_q;
  logic [6:0]       len_q;
  logic [23:0]      hold_q;
  logic             in_ready_q;
  logic             load_done_q;
  logic             cpu_hold_q;
  logic             word_wr;

  logic [31:0] mem [DEPTH];

  // A word is committed on the edge that accepts its fourth byte; the
  // incoming byte goes straight into the top lane, so no extra cycle is
  // needed to assemble it.
  assign word_wr  = (state_q == LOAD) && in_valid && (byte_cnt_q == 2'd3);
  assign wr_ptr_d = wr_ptr_q + 1'b1;

  // Control FSM. Outputs are registered alongside the state so they are
  // glitch-free and always consistent with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      hold_q      <= '0;
      in_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      cpu_hold_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            wr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            cpu_hold_q <= 1'b1;
            if (load_len == 7'd0) begin
              // Empty load: report completion without touching memory.
              state_q     <= DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
              len_q      <= (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
            end
          end
        end

        LOAD: begin
          if (in_valid) begin
            if (byte_cnt_q == 2'd3) begin
              wr_ptr_q   <= wr_ptr_d;
              byte_cnt_q <= '0;
              if (wr_ptr_d == len_q) begin
                state_q     <= DONE;
                in_ready_q  <= 1'b0;
                load_done_q <= 1'b1;
              end
            end else begin
              case (byte_cnt_q)
                2'd0:    hold_q[7:0]   <= in_byte;
                2'd1:    hold_q[15:8]  <= in_byte;
                default: hold_q[23:16] <= in_byte;
              endcase
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end

        DONE: begin
          state_q     <= IDLE;
          wr_ptr_q    <= '0;
          byte_cnt_q  <= '0;
          load_done_q <= 1'b0;
          cpu_hold_q  <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          load_done_q <= 1'b0;
          cpu_hold_q  <= 1'b0;
        end
      endcase
    end
  end

  // Instruction storage. Deliberately not reset: a program loaded before a
  // reset must survive it.
  always_ff @(posedge clk) begin
    if (word_wr) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= {in_byte, hold_q};
    end
  end

  assign in_ready    = in_ready_q;
  assign load_done   = load_done_q;
  assign cpu_hold    = cpu_hold_q;
  assign instruction = cpu_hold_q ? NOP_INSN : mem[address];

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction fetch path: loads a program into the 64-word instruction store.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Serves the fetch stage's combinational read port, and holds the core off while a load is in progress.
- Sits between the off-chip/debug byte source and the fetch stage, replacing the fixed-content instruction memory.

Parameters:
- DEPTH, 64, number of 32-bit instruction words.
- ADDR_W, 6, word address width; must satisfy 2**ADDR_W == DEPTH.
- NOP_INSN, 32'h00000013, word returned on the read port while loading (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- load_len  input  7  number of words to load; sampled with load_start.
- in_valid  input  1  byte source has a valid byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- load_done  output  1  one-cycle pulse when a load completes.
- cpu_hold  output  1  high while a load is active; the core must stay held.
- address  input  ADDR_W  fetch word address.
- instruction  output  32  fetch read data.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, wr_ptr=0, byte_cnt=0, len_q=0.
  - Outputs: in_ready=0, load_done=0, cpu_hold=0.
  - Storage array is not cleared; words written before reset keep their values.
- State machine: IDLE, LOAD, DONE. All outputs decode from registered state/counters.
  - in_ready=1 only in LOAD.
  - cpu_hold=1 in LOAD and DONE.
  - load_done=1 only in DONE.
- IDLE:
  - load_start=1, load_len=0 -> DONE next cycle (no writes).
  - load_start=1, load_len 1..64 -> LOAD; len_q=load_len, wr_ptr=0, byte_cnt=0.
  - load_len>64 -> clamp len_q to 64.
  - load_start is ignored in LOAD and DONE.
- LOAD:
  - A byte transfers on a rising edge with in_valid && in_ready.
  - Byte k of a word (k=byte_cnt, 0..3) goes into lane [8k+7:8k].
  - On the 4th byte, the same edge writes {b3,b2,b1,b0} to mem[wr_ptr] directly from the incoming byte plus the three held bytes, then increments wr_ptr and sets byte_cnt=0.
  - If the incremented wr_ptr equals len_q (7-bit compare, so 64 is reachable) -> DONE.
  - in_valid low: no state change; stalls of any length are legal.
- DONE: lasts exactly one cycle, then IDLE; wr_ptr and byte_cnt return to 0.
- Read port (combinational):
  - instruction = cpu_hold ? NOP_INSN : mem[address].
  - No latency; the fetch stage sees the new address within the same cycle.
- Throughput: one byte per cycle, so a word takes 4 cycles minimum. Load of N words ≥ 4N cycles in LOAD plus 1 in DONE.
- Boundaries:
  - Partial word at reset: discarded, no write.
  - Reset mid-load: immediate return to IDLE, cpu_hold drops; words already written persist.
  - wr_ptr never wraps within a load, because len_q ≤ 64.
  - Bytes offered outside LOAD are not accepted (in_ready=0) and have no effect.
- No X on any output after reset. mem contents read X only if never written.

Test Plan:
- Reset then IDLE, address=5 -> cpu_hold=0, in_ready=0, load_done=0; instruction = mem[5] (X if unwritten).
- load_start with len=2, stream 13 00 00 00 B3 00 A0 00 back-to-back:
  - in_ready=1 for 8 cycles, then load_done pulses for 1 cycle.
  - Afterwards mem[0]=32'h00000013, mem[1]=32'h00A000B3.
  - instruction=NOP_INSN throughout the load.
- Same load with in_valid toggled 1/0 every cycle -> identical contents; load_done arrives 8 cycles later than the back-to-back case.
- load_len=0 -> DONE one cycle after load_start; load_done pulse; no writes; in_ready never asserts.
- Reset asserted after 6 bytes of a 2-word load:
  - mem[0] is written, mem[1] is unchanged.
  - cpu_hold=0 immediately; a subsequent load restarts at wr_ptr=0.
- load_len=100 -> clamped to 64 words (256 bytes); load_start during LOAD is ignored; mem[63] is written with the last word.
